// File: rtl/hdb3_plug_b.sv
// HDB3 B-insertion stage: delays the V-stage code stream by four symbols and
// turns the first zero of a 000V group into B when the preceding mark count is even.
module hdb3_plug_b (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_plug_v_code,
    output logic [1:0] o_plug_b_code,
    output logic       o_valid,
    output logic       o_err
);

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_MARK = 2'b01;
    localparam logic [1:0] SYM_V    = 2'b10;
    localparam logic [1:0] SYM_B    = 2'b11;

    localparam logic [2:0] FILL_FULL = 3'd4;

    // Free-running stream: no handshake; one symbol in and one out every clock.
    logic [1:0] sr0_q, sr1_q, sr2_q, sr3_q;
    logic [1:0] sr0_d, sr3_d;
    logic       parity_q, parity_d;   // 1 = odd number of marks since last V
    logic [2:0] fill_q, fill_d;
    logic       err_q, err_d;
    logic       in_illegal;
    logic       in_v;

    assign in_illegal = (i_plug_v_code == SYM_B);
    assign in_v       = (i_plug_v_code == SYM_V);

    always_comb begin
        sr0_d    = in_illegal ? SYM_ZERO : i_plug_v_code;
        sr3_d    = sr2_q;
        parity_d = parity_q;
        fill_d   = fill_q;
        err_d    = in_illegal;

        // sr2 holds the first zero of the 000V group while V is at the input.
        if (in_v && !parity_q) begin
            sr3_d = SYM_B;
        end

        if (i_plug_v_code == SYM_MARK) begin
            parity_d = ~parity_q;
        end else if (in_v) begin
            parity_d = 1'b0;
        end

        if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 3'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr0_q    <= SYM_ZERO;
            sr1_q    <= SYM_ZERO;
            sr2_q    <= SYM_ZERO;
            sr3_q    <= SYM_ZERO;
            parity_q <= 1'b0;
            fill_q   <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            sr0_q    <= sr0_d;
            sr1_q    <= sr0_q;
            sr2_q    <= sr1_q;
            sr3_q    <= sr3_d;
            parity_q <= parity_d;
            fill_q   <= fill_d;
            err_q    <= err_d;
        end
    end

    assign o_plug_b_code = sr3_q;
    assign o_valid       = (fill_q == FILL_FULL);
    assign o_err         = err_q;

endmodule

// File: tb/tb_hdb3_plug_b.sv
// Bench for hdb3_plug_b: directed vectors plus a random HDB3 V-stage source,
// checked against a stream-level model of B insertion.
module tb_hdb3_plug_b;

  logic       i_clk;
  logic       i_rst_n;
  logic [1:0] i_plug_v_code;
  logic [1:0] o_plug_b_code;
  logic       o_valid;
  logic       o_err;

  int n_tests = 0;
  int n_fail  = 0;

  // model: encoded symbol history since last reset release, mark parity
  logic [1:0] hist[$];
  int         m_edges;
  bit         m_par;
  logic [1:0] exp_code;
  logic       exp_valid;
  logic       exp_err;

  hdb3_plug_b dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_plug_v_code(i_plug_v_code),
    .o_plug_b_code(o_plug_b_code),
    .o_valid      (o_valid),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic model_clear();
    hist.delete();
    m_edges   = 0;
    m_par     = 1'b0;
    exp_code  = 2'b00;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  // Reset asserted and released 1 time unit after a rising edge.
  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    i_plug_v_code = 2'b00;
    model_clear();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // Drive one symbol for one clock and advance the model; returns #1 after the edge.
  task automatic step(input logic [1:0] sym);
    logic [1:0] acc;
    @(negedge i_clk);
    i_plug_v_code = sym;
    @(posedge i_clk);
    acc = (sym == 2'b11) ? 2'b00 : sym;
    if (sym == 2'b10 && !m_par && hist.size() >= 3)
      hist[hist.size() - 3] = 2'b11;
    hist.push_back(acc);
    if (sym == 2'b01) m_par = !m_par;
    else if (sym == 2'b10) m_par = 1'b0;
    m_edges++;
    exp_err   = (sym == 2'b11);
    exp_valid = (m_edges >= 4);
    exp_code  = (m_edges >= 4) ? hist[m_edges - 4] : 2'b00;
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if (o_plug_b_code !== 2'b00 || o_valid !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: code=%b valid=%b err=%b required 00/0/0", o_plug_b_code, o_valid, o_err);
    end
    i_plug_v_code = 2'b01;
    repeat (3) @(negedge i_clk);
    n_tests++;
    if (o_plug_b_code !== 2'b00 || o_valid !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: code=%b valid=%b err=%b required 00/0/0", o_plug_b_code, o_valid, o_err);
    end
  endtask

  // Feed a directed vector then zeros; compare to literal expectations and the model.
  task automatic run_vector(input string name, input logic [1:0] vin[8], input logic [1:0] vout[8], input int len);
    do_reset();
    for (int i = 0; i < len + 4; i++) begin
      if (i < len) step(vin[i]);
      else step(2'b00);
      if (i >= 3 && i - 3 < len) begin
        n_tests++;
        if (o_plug_b_code !== vout[i - 3] || o_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s[%0d]: code=%b valid=%b required %b/1", name, i - 3, o_plug_b_code, o_valid, vout[i - 3]);
        end
      end
      n_tests++;
      if (o_plug_b_code !== exp_code) begin
        n_fail++;
        $display("FAIL %s_model[%0d]: code=%b required %b", name, i, o_plug_b_code, exp_code);
      end
    end
  endtask

  task automatic test_odd_parity();
    logic [1:0] vi[8];
    logic [1:0] vo[8];
    vi = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    vo = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    run_vector("odd_parity", vi, vo, 5);
  endtask

  task automatic test_even_parity();
    logic [1:0] vi[8];
    logic [1:0] vo[8];
    vi = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    vo = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    run_vector("even_parity", vi, vo, 6);
  endtask

  task automatic test_back_to_back();
    logic [1:0] vi[8];
    logic [1:0] vo[8];
    vi = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
    vo = '{2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10};
    run_vector("back_to_back", vi, vo, 8);
  endtask

  // Illegal symbol becomes zero, pulses err once, and leaves parity odd (no B later).
  task automatic test_illegal();
    logic [1:0] vi[8];
    logic [1:0] vo[8];
    vi = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    vo = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step((i < 6) ? vi[i] : 2'b00);
      n_tests++;
      if (o_err !== ((i == 1) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL illegal_err[%0d]: err=%b required %b", i, o_err, (i == 1));
      end
      if (i >= 3 && i - 3 < 6) begin
        n_tests++;
        if (o_plug_b_code !== vo[i - 3]) begin
          n_fail++;
          $display("FAIL illegal_code[%0d]: code=%b required %b", i - 3, o_plug_b_code, vo[i - 3]);
        end
      end
    end
  endtask

  task automatic test_valid_reset();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(2'b01);
      n_tests++;
      if (o_valid !== ((i >= 4) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL valid_rise[edge %0d]: valid=%b required %b", i, o_valid, (i >= 4));
      end
    end
    step(2'b00);
    step(2'b00);
    n_tests++;
    if (o_plug_b_code !== 2'b01 || o_plug_b_code !== exp_code) begin
      n_fail++;
      $display("FAIL pre_reset_code: code=%b required 01", o_plug_b_code);
    end
    // assert mid-cycle, away from any clock edge
    #1;
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_plug_b_code !== 2'b00 || o_valid !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: code=%b valid=%b err=%b required 00/0/0", o_plug_b_code, o_valid, o_err);
    end
    model_clear();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(2'b00);
      n_tests++;
      if (o_plug_b_code !== 2'b00 || o_valid !== ((i >= 4) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL post_reset[edge %0d]: code=%b valid=%b required 00/%b", i, o_plug_b_code, o_valid, (i >= 4));
      end
    end
  endtask

  // Random binary data through an HDB3 V-stage source; model plus stream properties.
  task automatic test_random();
    int         zr;
    int         zero_run;
    int         marks;
    logic [1:0] sym;
    do_reset();
    zr = 0;
    zero_run = 0;
    marks = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        sym = 2'b01;
        zr = 0;
      end else if (zr == 3) begin
        sym = 2'b10;
        zr = 0;
      end else begin
        sym = 2'b00;
        zr++;
      end
      step(sym);
      n_tests++;
      if (o_plug_b_code !== exp_code || o_valid !== exp_valid || o_err !== exp_err) begin
        n_fail++;
        $display("FAIL random[%0d]: code=%b valid=%b err=%b required %b/%b/%b",
                 i, o_plug_b_code, o_valid, o_err, exp_code, exp_valid, exp_err);
      end
      if (o_valid === 1'b1) begin
        if (o_plug_b_code == 2'b00) zero_run++;
        else zero_run = 0;
        n_tests++;
        if (zero_run > 3) begin
          n_fail++;
          $display("FAIL zero_run[%0d]: run=%0d required <=3", i, zero_run);
        end
        if (o_plug_b_code == 2'b01 || o_plug_b_code == 2'b11) marks++;
        if (o_plug_b_code == 2'b10) begin
          n_tests++;
          if (marks % 2 != 1) begin
            n_fail++;
            $display("FAIL v_parity[%0d]: marks=%0d required odd", i, marks);
          end
          marks = 0;
        end
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_plug_v_code = 2'b00;
    model_clear();
    test_reset();
    test_odd_parity();
    test_even_parity();
    test_back_to_back();
    test_illegal();
    test_valid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hdb3_plug_b.md
HDB3_PLUG_B -- requirements
Module: hdb3_plug_b

Interface
REQ-001 Parameters: none; code width is fixed at 2 bits.
REQ-002 i_clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_plug_v_code  input  2  code stream from the V-insertion stage, one symbol per clock.
REQ-005 o_plug_b_code  output  2  code stream with B symbols inserted, one symbol per clock.
REQ-006 o_valid  output  1  high once the delay line holds real input symbols.
REQ-007 o_err  output  1  one-cycle registered pulse flagging an illegal input symbol.

Function
REQ-008 Symbol encoding on both code ports: 2'b00 zero, 2'b01 mark (one), 2'b10 V, 2'b11 B.
REQ-009 Input 2'b11 is illegal: it enters the delay line as 2'b00, does not change parity, and sets o_err high on the following cycle only.
REQ-010 The block is a 4-stage shift register sr[0..3] (sr[0] newest); each clock, sr[0] <= input, sr[k] <= sr[k-1].
REQ-011 o_plug_b_code = sr[3], so the fixed latency input-to-output is 4 clocks, with no bubbles.
REQ-012 A parity bit tracks marks accepted since the last V: it toggles on input 2'b01, clears to even on input 2'b10, and holds otherwise.
REQ-013 On a clock where the input is 2'b10 and parity (before update) is even, sr[3] loads 2'b11 instead of sr[2]; this replaces the first zero of the 000V group.
REQ-014 On a clock where the input is 2'b10 and parity is odd, the shift is unmodified.
REQ-015 The first V after reset sees even parity and therefore gets a B.
REQ-016 Back-to-back 000V groups: the parity cleared by the first V applies to the second, so the second group also receives B unless marks intervene.
REQ-017 B substitution never overwrites a non-zero symbol; the upstream guarantees that sr[2] is 2'b00 whenever the input is V, and the block does not re-check this.
REQ-018 A 3-bit fill counter increments per clock after reset and saturates at 4; o_valid = 1 when the counter equals 4.
REQ-019 Symbols output while o_valid = 0 are reset fill (2'b00) and are not encoded data.

Reset
REQ-020 On i_rst_n low: sr[0..3] = 2'b00, parity = even, fill counter = 0, o_plug_b_code = 2'b00, o_valid = 0, o_err = 0, all immediately and regardless of the clock.
REQ-021 Reset asserted mid-stream discards the pipeline contents, and no partial group is emitted after release.
REQ-022 Operation resumes on the first rising edge after i_rst_n returns high.

Verification
REQ-023 Odd parity: after reset, input 01,00,00,00,10 -> output 01,00,00,00,10 starting 4 clocks later, with no B.
REQ-024 Even parity: input 01,01,00,00,00,10 -> output 01,01,11,00,00,10.
REQ-025 First V after reset and back-to-back groups: input 00,00,00,10,00,00,00,10 -> output 11,00,00,10,11,00,00,10.
REQ-026 Illegal symbol: input 01,11,00 -> output 01,00,00; o_err high exactly one cycle, the cycle after 11 is sampled; parity stays odd.
REQ-027 Valid and reset: o_valid rises on the 4th rising edge after release; asserting i_rst_n mid-group clears the output to 00 and o_valid to 0 asynchronously.
REQ-028 Continuous run with the upstream pulse source: no output run exceeds three consecutive 00 symbols once o_valid = 1, and every V is preceded by an odd number of marks/B since the previous V.
